// File: rtl/id_ex.sv
// -----------------------------------------------------------------------------
// id_ex -- decode-to-execute pipeline register with a one-entry skid buffer.
//
// Purpose:
//   Carries one decoded instruction (ALU op, result select, two operands,
//   destination register and write enable) from decode to execute using a
//   valid/ready handshake on both sides. A main slot drives the ex_* outputs.
//   A skid slot catches the instruction accepted in the cycle that execute
//   stalls, which lets id_ready be a plain register. Flush drops everything
//   held. A saturating counter records how many cycles execute applied
//   back-pressure to a valid instruction.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous, active-high reset
//   id_valid   in   1   decode presents an instruction
//   id_ready   out  1   this block can accept an instruction (registered)
//   id_aluop   in   8   ALU operation code
//   id_alusel  in   3   ALU result-select code
//   id_reg1    in  32   source operand 1
//   id_reg2    in  32   source operand 2
//   id_wd      in   5   destination register address
//   id_wreg    in   1   destination write enable
//   flush      in   1   discard all held instructions
//   ex_valid   out  1   execute-side instruction valid
//   ex_ready   in   1   execute consumes the instruction this cycle
//   ex_aluop   out  8   registered ALU operation code (NOP when invalid)
//   ex_alusel  out  3   registered result select (0 when invalid)
//   ex_reg1    out 32   registered operand 1 (0 when invalid)
//   ex_reg2    out 32   registered operand 2 (0 when invalid)
//   ex_wd      out  5   registered destination address (0 when invalid)
//   ex_wreg    out  1   registered write enable (0 when invalid)
//   stall_cnt  out 16   saturating count of back-pressured cycles
// -----------------------------------------------------------------------------
module id_ex (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [7:0]  id_aluop,
    input  logic [2:0]  id_alusel,
    input  logic [31:0] id_reg1,
    input  logic [31:0] id_reg2,
    input  logic [4:0]  id_wd,
    input  logic        id_wreg,
    input  logic        flush,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [7:0]  ex_aluop,
    output logic [2:0]  ex_alusel,
    output logic [31:0] ex_reg1,
    output logic [31:0] ex_reg2,
    output logic [4:0]  ex_wd,
    output logic        ex_wreg,
    output logic [15:0] stall_cnt
);

    // One instruction's worth of payload.
    typedef struct packed {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [4:0]  wd;
        logic        wreg;
    } slot_t;

    // All-zero payload doubles as the NOP presented when nothing is valid.
    localparam slot_t NOP_SLOT = '0;

    slot_t       incoming;
    slot_t       main_q;
    slot_t       main_d;
    slot_t       skid_q;
    slot_t       skid_d;
    logic        main_valid_q;
    logic        main_valid_d;
    logic        skid_valid_q;
    logic        skid_valid_d;
    logic        id_ready_q;
    logic        id_ready_d;
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;

    logic        accept;
    logic        consume;
    logic        stalled;

    assign incoming = {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg};

    assign accept   = id_valid && id_ready_q;
    assign consume  = main_valid_q && ex_ready;
    assign stalled  = main_valid_q && !ex_ready;

    // Next-state logic for both slots, the ready flag and the stall counter.
    // The main slot's payload is forced to NOP whenever it goes invalid, so
    // the outputs can be driven straight from the register.
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;

        // Counting continues through flushes; only reset clears it.
        if (stalled && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end

        if (flush) begin
            main_d       = NOP_SLOT;
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || consume) begin
            // Main slot is free at this edge. The skid entry is older than
            // anything on the input, and id_ready is low while it is full,
            // so an accept cannot collide with the skid refill.
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = incoming;
                main_valid_d = 1'b1;
            end else begin
                main_d       = NOP_SLOT;
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            // Main is held by a stalled execute stage; park the newcomer.
            skid_d       = incoming;
            skid_valid_d = 1'b1;
        end

        id_ready_d = !skid_valid_d;
    end

    // State registers with synchronous reset taking priority over all else.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= NOP_SLOT;
            main_valid_q <= 1'b0;
            skid_q       <= NOP_SLOT;
            skid_valid_q <= 1'b0;
            id_ready_q   <= 1'b1;
            stall_cnt_q  <= 16'h0000;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            id_ready_q   <= id_ready_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign id_ready  = id_ready_q;
    assign ex_valid  = main_valid_q;
    assign ex_aluop  = main_q.aluop;
    assign ex_alusel = main_q.alusel;
    assign ex_reg1   = main_q.reg1;
    assign ex_reg2   = main_q.reg2;
    assign ex_wd     = main_q.wd;
    assign ex_wreg   = main_q.wreg;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex.sv
// -----------------------------------------------------------------------------
// tb_id_ex -- self-checking bench for id_ex.
//
// The reference model is a FIFO of accepted-but-not-issued instructions:
// its head is what execute should see, its depth bounds id_ready, and the
// stall counter is a plain saturating integer.
// -----------------------------------------------------------------------------
module tb_id_ex;

    typedef logic [80:0] instr_t;   // {aluop, alusel, reg1, reg2, wd, wreg}

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [7:0]  id_aluop;
    logic [2:0]  id_alusel;
    logic [31:0] id_reg1;
    logic [31:0] id_reg2;
    logic [4:0]  id_wd;
    logic        id_wreg;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [7:0]  ex_aluop;
    logic [2:0]  ex_alusel;
    logic [31:0] ex_reg1;
    logic [31:0] ex_reg2;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [15:0] stall_cnt;

    int totalChecks = 0;
    int badChecks   = 0;

    // Reference model state.
    instr_t inFlight[$];
    int     modelStall = 0;
    int     issuedCount = 0;

    id_ex dut (
        .clk       (clk),
        .rst       (rst),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_aluop  (id_aluop),
        .id_alusel (id_alusel),
        .id_reg1   (id_reg1),
        .id_reg2   (id_reg2),
        .id_wd     (id_wd),
        .id_wreg   (id_wreg),
        .flush     (flush),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_aluop  (ex_aluop),
        .ex_alusel (ex_alusel),
        .ex_reg1   (ex_reg1),
        .ex_reg2   (ex_reg2),
        .ex_wd     (ex_wd),
        .ex_wreg   (ex_wreg),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic instr_t makeInstr(input logic [7:0] op, input logic [2:0] sel,
                                         input logic [31:0] r1, input logic [31:0] r2,
                                         input logic [4:0] wd, input logic wr);
        return {op, sel, r1, r2, wd, wr};
    endfunction

    function automatic instr_t randInstr();
        return makeInstr(8'($urandom), 3'($urandom), $urandom, $urandom,
                         5'($urandom), 1'($urandom));
    endfunction

    // Model view of the execute side: the oldest in-flight instruction, or NOP.
    function automatic instr_t expectedEx();
        if (inFlight.size() > 0) return inFlight[0];
        return '0;
    endfunction

    function automatic instr_t observedEx();
        return {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg};
    endfunction

    task automatic driveInputs(input logic v, input instr_t d, input logic rdy,
                               input logic fl, input logic rs);
        id_valid = v;
        {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg} = d;
        ex_ready = rdy;
        flush    = fl;
        rst      = rs;
    endtask

    // Advance one clock: update the model from the inputs in force before the
    // edge, then let the edge happen and step 1 time unit past it.
    task automatic applyStimulus();
        bit canAccept;
        canAccept = (inFlight.size() < 2);
        if (rst) begin
            inFlight.delete();
            modelStall = 0;
        end else begin
            if (inFlight.size() > 0 && !ex_ready && modelStall < 65535)
                modelStall++;
            if (flush) begin
                inFlight.delete();
            end else begin
                if (inFlight.size() > 0 && ex_ready) begin
                    void'(inFlight.pop_front());
                    issuedCount++;
                end
                if (id_valid && canAccept)
                    inFlight.push_back({id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        driveInputs(1'b0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus();
        totalChecks++;
        if (ex_valid !== 1'b0 || id_ready !== 1'b1 || stall_cnt !== 16'h0 || observedEx() !== '0) begin
            badChecks++;
            $display("[TB] FAIL reset_initial: valid=%b ready=%b cnt=%h ex=%h required valid=0 ready=1 cnt=0 ex=0",
                     ex_valid, id_ready, stall_cnt, observedEx());
        end
        // Fill both slots while stalled, then reset.
        driveInputs(1'b0, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        driveInputs(1'b1, makeInstr(8'h11, 3'd1, 32'hA, 32'hB, 5'd1, 1'b1), 1'b0, 1'b0, 1'b0);
        applyStimulus();
        driveInputs(1'b1, makeInstr(8'h22, 3'd2, 32'hC, 32'hD, 5'd2, 1'b1), 1'b0, 1'b0, 1'b0);
        applyStimulus();
        driveInputs(1'b0, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        totalChecks++;
        if (id_ready !== 1'b0 || ex_valid !== 1'b1 || stall_cnt === 16'h0) begin
            badChecks++;
            $display("[TB] FAIL reset_prefill: ready=%b valid=%b cnt=%h required ready=0 valid=1 cnt>0",
                     id_ready, ex_valid, stall_cnt);
        end
        driveInputs(1'b0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus();
        totalChecks++;
        if (ex_valid !== 1'b0 || ex_aluop !== 8'h00 || id_ready !== 1'b1 || stall_cnt !== 16'h0
            || observedEx() !== '0) begin
            badChecks++;
            $display("[TB] FAIL reset_full: valid=%b aluop=%h ready=%b cnt=%h required 0/00/1/0000",
                     ex_valid, ex_aluop, id_ready, stall_cnt);
        end
        // First accept is possible in the first cycle after reset.
        driveInputs(1'b1, makeInstr(8'h33, 3'd3, 32'h5, 32'h6, 5'd7, 1'b0), 1'b1, 1'b0, 1'b0);
        applyStimulus();
        totalChecks++;
        if (ex_valid !== 1'b1 || ex_aluop !== 8'h33 || ex_wd !== 5'd7) begin
            badChecks++;
            $display("[TB] FAIL reset_first_accept: valid=%b aluop=%h wd=%0d required 1/33/7",
                     ex_valid, ex_aluop, ex_wd);
        end
        driveInputs(1'b0, '0, 1'b1, 1'b0, 1'b0);
        applyStimulus();
    endtask

    task automatic test_streaming();
        instr_t ori [3];
        for (int i = 0; i < 3; i++)
            ori[i] = makeInstr(8'h25, 3'd1, 32'h1234, 32'(i + 1), 5'd3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            driveInputs(1'b1, ori[i], 1'b1, 1'b0, 1'b0);
            applyStimulus();
            totalChecks++;
            if (ex_valid !== 1'b1 || observedEx() !== ori[i] || id_ready !== 1'b1) begin
                badChecks++;
                $display("[TB] FAIL stream_%0d: valid=%b ready=%b ex=%h required valid=1 ready=1 ex=%h",
                         i, ex_valid, id_ready, observedEx(), ori[i]);
            end
        end
        driveInputs(1'b0, '0, 1'b1, 1'b0, 1'b0);
        applyStimulus();
        totalChecks++;
        if (ex_valid !== 1'b0 || observedEx() !== '0) begin
            badChecks++;
            $display("[TB] FAIL stream_drain: valid=%b ex=%h required valid=0 ex=0", ex_valid, observedEx());
        end
    endtask

    task automatic test_back_pressure();
        instr_t a;
        instr_t b;
        a = makeInstr(8'hA1, 3'd5, 32'hAAAA_0001, 32'hAAAA_0002, 5'd10, 1'b1);
        b = makeInstr(8'hB2, 3'd6, 32'hBBBB_0001, 32'hBBBB_0002, 5'd11, 1'b0);
        driveInputs(1'b1, a, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        driveInputs(1'b1, b, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        totalChecks++;
        if (observedEx() !== a || ex_valid !== 1'b1 || id_ready !== 1'b0) begin
            badChecks++;
            $display("[TB] FAIL bp_hold: ex=%h valid=%b ready=%b required ex=%h valid=1 ready=0",
                     observedEx(), ex_valid, id_ready, a);
        end
        // Keep offering a third instruction; it must not be taken.
        for (int i = 0; i < 4; i++) begin
            driveInputs(1'b1, randInstr(), 1'b0, 1'b0, 1'b0);
            applyStimulus();
            totalChecks++;
            if (observedEx() !== a || id_ready !== 1'b0 || stall_cnt !== 16'(modelStall)) begin
                badChecks++;
                $display("[TB] FAIL bp_stall_%0d: ex=%h ready=%b cnt=%0d required ex=%h ready=0 cnt=%0d",
                         i, observedEx(), id_ready, stall_cnt, a, modelStall);
            end
        end
        driveInputs(1'b0, '0, 1'b1, 1'b0, 1'b0);
        applyStimulus();
        totalChecks++;
        if (observedEx() !== b || ex_valid !== 1'b1 || id_ready !== 1'b1) begin
            badChecks++;
            $display("[TB] FAIL bp_release_b: ex=%h valid=%b ready=%b required ex=%h valid=1 ready=1",
                     observedEx(), ex_valid, id_ready, b);
        end
        applyStimulus();
        totalChecks++;
        if (ex_valid !== 1'b0 || stall_cnt !== 16'(modelStall)) begin
            badChecks++;
            $display("[TB] FAIL bp_drain: valid=%b cnt=%0d required valid=0 cnt=%0d",
                     ex_valid, stall_cnt, modelStall);
        end
    endtask

    task automatic test_flush();
        int issuedBefore;
        driveInputs(1'b1, makeInstr(8'h01, 3'd1, 32'h1, 32'h1, 5'd1, 1'b1), 1'b0, 1'b0, 1'b0);
        applyStimulus();
        driveInputs(1'b1, makeInstr(8'h02, 3'd2, 32'h2, 32'h2, 5'd2, 1'b1), 1'b0, 1'b0, 1'b0);
        applyStimulus();
        issuedBefore = issuedCount;
        driveInputs(1'b1, makeInstr(8'h03, 3'd3, 32'h3, 32'h3, 5'd3, 1'b1), 1'b0, 1'b1, 1'b0);
        applyStimulus();
        totalChecks++;
        if (ex_valid !== 1'b0 || observedEx() !== '0 || id_ready !== 1'b1
            || stall_cnt !== 16'(modelStall)) begin
            badChecks++;
            $display("[TB] FAIL flush_full: valid=%b ex=%h ready=%b cnt=%0d required 0/0/1/%0d",
                     ex_valid, observedEx(), ready_str(), stall_cnt, modelStall);
        end
        driveInputs(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            totalChecks++;
            if (ex_valid !== 1'b0) begin
                badChecks++;
                $display("[TB] FAIL flush_no_issue_%0d: valid=%b required 0", i, ex_valid);
            end
        end
        // Flush with only main held, plus a real same-cycle accept.
        driveInputs(1'b1, makeInstr(8'h04, 3'd4, 32'h4, 32'h4, 5'd4, 1'b0), 1'b0, 1'b0, 1'b0);
        applyStimulus();
        driveInputs(1'b1, makeInstr(8'h05, 3'd5, 32'h5, 32'h5, 5'd5, 1'b1), 1'b0, 1'b1, 1'b0);
        applyStimulus();
        totalChecks++;
        if (ex_valid !== 1'b0 || observedEx() !== '0 || id_ready !== 1'b1 || issuedCount !== issuedBefore) begin
            badChecks++;
            $display("[TB] FAIL flush_accept: valid=%b ex=%h ready=%b required 0/0/1",
                     ex_valid, observedEx(), id_ready);
        end
        driveInputs(1'b0, '0, 1'b1, 1'b0, 1'b0);
        applyStimulus();
    endtask

    function automatic logic ready_str();
        return id_ready;
    endfunction

    task automatic test_reset_mid_transfer();
        driveInputs(1'b1, makeInstr(8'h77, 3'd7, 32'h77, 32'h77, 5'd7, 1'b1), 1'b1, 1'b0, 1'b1);
        applyStimulus();
        totalChecks++;
        if (ex_valid !== 1'b0 || observedEx() !== '0 || id_ready !== 1'b1 || stall_cnt !== 16'h0) begin
            badChecks++;
            $display("[TB] FAIL reset_mid: valid=%b ex=%h ready=%b cnt=%h required 0/0/1/0",
                     ex_valid, observedEx(), id_ready, stall_cnt);
        end
        driveInputs(1'b0, '0, 1'b1, 1'b0, 1'b0);
        applyStimulus();
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            driveInputs(1'($urandom_range(0, 99) < 70), randInstr(),
                        1'($urandom_range(0, 99) < 55),
                        1'($urandom_range(0, 99) < 4),
                        1'($urandom_range(0, 99) < 2));
            applyStimulus();
            totalChecks++;
            if (ex_valid !== (inFlight.size() > 0) || id_ready !== (inFlight.size() < 2)
                || observedEx() !== expectedEx() || stall_cnt !== 16'(modelStall)) begin
                badChecks++;
                if (errs < 10)
                    $display("[TB] FAIL random_%0d: valid=%b ready=%b ex=%h cnt=%0d required valid=%b ready=%b ex=%h cnt=%0d",
                             i, ex_valid, id_ready, observedEx(), stall_cnt,
                             inFlight.size() > 0, inFlight.size() < 2, expectedEx(), modelStall);
                errs++;
            end
        end
        driveInputs(1'b0, '0, 1'b1, 1'b0, 1'b0);
        applyStimulus();
        applyStimulus();
    endtask

    task automatic test_saturation();
        driveInputs(1'b0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus();
        driveInputs(1'b1, makeInstr(8'h55, 3'd2, 32'h55, 32'h55, 5'd9, 1'b1), 1'b0, 1'b0, 1'b0);
        applyStimulus();
        driveInputs(1'b0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 65540; i++)
            applyStimulus();
        totalChecks++;
        if (stall_cnt !== 16'hFFFF || modelStall != 65535) begin
            badChecks++;
            $display("[TB] FAIL sat_reach: cnt=%h required FFFF", stall_cnt);
        end
        for (int i = 0; i < 5; i++)
            applyStimulus();
        totalChecks++;
        if (stall_cnt !== 16'hFFFF || ex_aluop !== 8'h55) begin
            badChecks++;
            $display("[TB] FAIL sat_hold: cnt=%h aluop=%h required FFFF/55", stall_cnt, ex_aluop);
        end
        driveInputs(1'b0, '0, 1'b0, 1'b1, 1'b0);
        applyStimulus();
        totalChecks++;
        if (stall_cnt !== 16'hFFFF || ex_valid !== 1'b0) begin
            badChecks++;
            $display("[TB] FAIL sat_flush: cnt=%h valid=%b required FFFF/0", stall_cnt, ex_valid);
        end
        driveInputs(1'b0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus();
        totalChecks++;
        if (stall_cnt !== 16'h0) begin
            badChecks++;
            $display("[TB] FAIL sat_reset: cnt=%h required 0000", stall_cnt);
        end
    endtask

    initial begin
        driveInputs(1'b0, '0, 1'b0, 1'b0, 1'b1);
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_reset_mid_transfer();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
